mux_pipe_n: RTL and testbench
=============================

Name: mux_pipe_n

Overview:
- Parametrised successor of the 2:1 datapath selectors.
- Selects one of N WIDTH-bit sources per transaction.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the pipelined datapath can stall without losing or duplicating selections.
- Used for the register-destination, ALU-operand and write-back selection points between pipeline stages.

Parameters:
- WIDTH, 5, data width of each source and of the output.
- N, 2, number of sources; legal range 2..16.
- SEL_W, $clog2(N) with a minimum of 1, width of the select field; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a_flat  input  N*WIDTH  packed sources; source i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SEL_W  source index, sampled with the beat.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat.
- y  output  WIDTH  selected data (head of buffer).
- y_err  output  1  head beat had sel >= N.
- out_valid  output  1  y/y_err valid.
- out_ready  input  1  downstream accepts the head.

Behaviour:
- Accept: in_valid & in_ready at a rising edge. Drain: out_valid & out_ready at a rising edge.
- Selection on accept: data = a_flat[sel*WIDTH +: WIDTH] when sel < N.
- Out-of-range sel (sel >= N, possible when N is not a power of 2): data = 0 and err = 1.
- Storage: a main register (head, drives y/y_err) and a skid register. Each holds {data, err, valid}.
- State machine, encoded by valid bits:
  - EMPTY: no beats held.
    - Accept -> ONE; head loads the new beat.
  - ONE: head holds one beat.
    - Accept and drain -> stay ONE; head loads the new beat.
    - Accept only -> TWO; skid loads the new beat.
    - Drain only -> EMPTY.
  - TWO: head and skid both hold beats.
    - Drain -> ONE; head loads skid, skid cleared.
    - Accept is impossible in TWO.
- Handshake outputs:
  - in_ready = !rst & (state != TWO); depends only on state, never combinationally on out_ready.
  - out_valid = state != EMPTY.
- Latency: 1 cycle from accept to out_valid when EMPTY. Full throughput of 1 beat/cycle while out_ready is held high.
- Ordering: strict FIFO. Beats are never reordered, duplicated or dropped.
- Stability: y and y_err stay stable while out_valid & !out_ready.
- Data values of registers that are not valid are don't-care, but are cleared to 0 so that y reads 0 when EMPTY.
- Reset: asynchronous, any cycle, including mid-transfer.
  - Forces EMPTY, y = 0, y_err = 0, out_valid = 0, in_ready = 0 while asserted.
  - In-flight beats are discarded.
  - in_ready rises in the first cycle after deassertion.
- Sources a_flat are not required to stay stable after the accept edge.

Optional Feature:
- Macro: MUX_PIPE_STATS_EN.
- Defined:
  - Adds output port beat_cnt [15:0], counting drained beats.
  - Adds output port err_cnt [15:0], counting drained beats with y_err = 1.
  - Both counters saturate at 16'hFFFF and reset to 0 with rst.
  - They increment in the same edge as the drain.
- Undefined: the ports and counters do not exist. Handshake and data behaviour are identical in both builds.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - the state encoding constants (ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2);
  - a function sel_width(n) returning max(1, $clog2(n));
  - the counter width constant STAT_W = 16.
- One natural sub-module: mux_sel_n, purely combinational. It maps (a_flat, sel) to (data, err) and is parametrised on WIDTH and N. The top level owns the state, the registers and the optional counters.

Test Plan:
- Reset and first beat, WIDTH=5, N=3: hold rst for 2 cycles, then a_flat = {5'd7, 5'd20, 5'd9}, sel = 1, in_valid for 1 cycle -> during reset in_ready=0 and out_valid=0; the next cycle gives y=20, y_err=0, out_valid=1.
- Out-of-range select, N=3: sel=3 -> y=0, y_err=1; with stats enabled, err_cnt=1 after the drain.
- Back-pressure fill: out_ready=0, send beats with sel=0 then sel=2 -> state TWO, in_ready=0, y=9 held stable. Raise out_ready -> y=9, then y=7 on consecutive cycles, then out_valid=0.
- Streaming: out_ready=1, 100 consecutive beats with random sel < 3 -> 100 outputs in order, one per cycle, in_ready never drops.
- Reset mid-operation: in state TWO, assert rst asynchronously between edges -> out_valid and y drop to 0 immediately, with no residual beat after release.
- Stats saturation, MUX_PIPE_STATS_EN, counter preloaded via force to 16'hFFFE: drain 3 beats -> beat_cnt=16'hFFFF and it does not wrap.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared constants and helpers for the N-way pipelined selector.
// Holds the skid-buffer state encoding, the select-width helper and the
// statistics counter width.
package mips_pipe_pkg;

  // Occupancy of the two-entry skid buffer
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Width of the optional drain / error counters
  localparam int unsigned STAT_W = 16;

  // Select field width: ceil(log2(n)), never below one bit
  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = 32'($clog2(n));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_sel_n.sv
// Combinational N-way selector.
// Ports:
//   a_flat : N packed WIDTH-bit sources, source i at [i*WIDTH +: WIDTH]
//   sel    : source index
//   data   : selected source, 0 when sel is out of range
//   err    : sel >= N
module mux_sel_n
  import mips_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned N     = 2,
  parameter int unsigned SEL_W = sel_width(N)
) (
  input  logic [N*WIDTH-1:0] a_flat,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   data,
  output logic               err
);

  // Compare against every legal index; out-of-range selects fall through to 0
  always_comb begin
    data = '0;
    err  = (32'(sel) >= N);
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(sel) == i) begin
        data = a_flat[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// N-way selector registered behind a valid/ready handshake with a
// two-entry skid buffer (head drives y/y_err, skid absorbs one stall).
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   a_flat, sel         : packed sources and source index, sampled on accept
//   in_valid, in_ready  : upstream handshake (in_ready depends on state only)
//   y, y_err, out_valid : head beat and its out-of-range flag
//   out_ready           : downstream accepts the head
//   beat_cnt, err_cnt   : saturating drain counters, present only when
//                         MUX_PIPE_STATS_EN is defined
module mux_pipe_n
  import mips_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned N     = 2,
  // Derived from N; do not override
  parameter int unsigned SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] a_flat,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   y,
  output logic               y_err,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_PIPE_STATS_EN
  ,
  output logic [STAT_W-1:0]  beat_cnt,
  output logic [STAT_W-1:0]  err_cnt
`endif
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             head_err_q, head_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             accept;
  logic             drain;

  mux_sel_n #(
    .WIDTH (WIDTH),
    .N     (N),
    .SEL_W (SEL_W)
  ) u_sel (
    .a_flat (a_flat),
    .sel    (sel),
    .data   (sel_data),
    .err    (sel_err)
  );

  // Handshake decoded from registered state only
  assign in_ready  = !rst && (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  assign y     = head_data_q;
  assign y_err = head_err_q;

  // State and payload register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_err_q  <= head_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

  // Next state; invalid entries are zeroed so y reads 0 when empty
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_err_d  = head_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          head_data_d = sel_data;
          head_err_d  = sel_err;
        end
      end

      ST_ONE: begin
        if (accept && drain) begin
          head_data_d = sel_data;
          head_err_d  = sel_err;
        end else if (accept) begin
          state_d     = ST_TWO;
          skid_data_d = sel_data;
          skid_err_d  = sel_err;
        end else if (drain) begin
          state_d     = ST_EMPTY;
          head_data_d = '0;
          head_err_d  = 1'b0;
        end
      end

      ST_TWO: begin
        // in_ready is low here, so only a drain can happen
        if (drain) begin
          state_d     = ST_ONE;
          head_data_d = skid_data_q;
          head_err_d  = skid_err_q;
          skid_data_d = '0;
          skid_err_d  = 1'b0;
        end
      end

      default: begin
        state_d     = ST_EMPTY;
        head_data_d = '0;
        head_err_d  = 1'b0;
        skid_data_d = '0;
        skid_err_d  = 1'b0;
      end
    endcase
  end

`ifdef MUX_PIPE_STATS_EN
  logic [STAT_W-1:0] beat_cnt_q;
  logic [STAT_W-1:0] err_cnt_q;

  // Saturating drain counters, updated on the drain edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (drain) begin
      if (beat_cnt_q != '1) begin
        beat_cnt_q <= beat_cnt_q + STAT_W'(1);
      end
      if (head_err_q && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + STAT_W'(1);
      end
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Self-checking bench for mux_pipe_n with WIDTH=5, N=3.
// Optional counter checks are compiled when MUX_PIPE_STATS_EN is defined.
module tb_mux_pipe_n;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned N     = 3;
  localparam int unsigned SEL_W = 2;

  logic               clk;
  logic               rst;
  logic [N*WIDTH-1:0] a_flat;
  logic [SEL_W-1:0]   sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   y;
  logic               y_err;
  logic               out_valid;
  logic               out_ready;
`ifdef MUX_PIPE_STATS_EN
  logic [15:0]        beat_cnt;
  logic [15:0]        err_cnt;
`endif

  int total;
  int bad;

  mux_pipe_n #(
    .WIDTH (WIDTH),
    .N     (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_flat    (a_flat),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .y_err     (y_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_PIPE_STATS_EN
    ,
    .beat_cnt  (beat_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel_v;
    logic       valid_v;
    logic       oready_v;
    logic [4:0] exp_y;
    logic       exp_err;
    logic       exp_ov;
    logic       exp_ir;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] src [3];
  logic [4:0] exp_q [$];
  logic [4:0] exp_v;
  int         s;

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    a_flat    = {5'd7, 5'd20, 5'd9};
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    //            sel   vld   ordy  y      err   ov    ir
    vecs[0]  = '{2'd1, 1'b1, 1'b0, 5'd20, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{2'd0, 1'b1, 1'b0, 5'd20, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{2'd2, 1'b1, 1'b0, 5'd20, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{2'd0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 1'b1};
    vecs[4]  = '{2'd3, 1'b1, 1'b1, 5'd0,  1'b1, 1'b1, 1'b1};
    vecs[5]  = '{2'd2, 1'b1, 1'b1, 5'd7,  1'b0, 1'b1, 1'b1};
    vecs[6]  = '{2'd0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1};
    vecs[7]  = '{2'd0, 1'b1, 1'b1, 5'd9,  1'b0, 1'b1, 1'b1};
    vecs[8]  = '{2'd1, 1'b1, 1'b0, 5'd9,  1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2'd0, 1'b0, 1'b1, 5'd20, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{2'd0, 1'b0, 1'b0, 5'd20, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{2'd0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1};

    // Reset held for two cycles
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("rst_y", 32'(y), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table, each row is one cycle
    for (int i = 0; i < 12; i++) begin
      sel       = vecs[i].sel_v;
      in_valid  = vecs[i].valid_v;
      out_ready = vecs[i].oready_v;
      tick();
      check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].exp_y));
      check($sformatf("vec%0d_err", i), 32'(y_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d_ir", i), 32'(in_ready), 32'(vecs[i].exp_ir));
    end
`ifdef MUX_PIPE_STATS_EN
    check("table_beat_cnt", 32'(beat_cnt), 32'd6);
    check("table_err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Back-pressure fill then drain
    in_valid  = 1'b1;
    out_ready = 1'b0;
    sel       = 2'd0;
    tick();
    sel = 2'd2;
    tick();
    in_valid = 1'b0;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_y_head", 32'(y), 32'd9);
    a_flat = {5'd1, 5'd2, 5'd3};
    tick();
    check("bp_y_stable", 32'(y), 32'd9);
    a_flat    = {5'd7, 5'd20, 5'd9};
    out_ready = 1'b1;
    tick();
    check("bp_y_second", 32'(y), 32'd7);
    check("bp_ov_second", 32'(out_valid), 32'd1);
    tick();
    check("bp_ov_empty", 32'(out_valid), 32'd0);

    // Streaming at full rate with changing sources
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      for (int k = 0; k < 3; k++) src[k] = 5'($urandom);
      s        = int'($urandom_range(0, 2));
      a_flat   = {src[2], src[1], src[0]};
      sel      = 2'(s);
      in_valid = 1'b1;
      exp_q.push_back(src[s]);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      exp_v = exp_q.pop_front();
      check("stream_y", 32'(y), 32'(exp_v));
      check("stream_ov", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_done_ov", 32'(out_valid), 32'd0);

    // Asynchronous reset while two beats are held
    a_flat    = {5'd7, 5'd20, 5'd9};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd1;
    tick();
    tick();
    in_valid = 1'b0;
    check("pre_rst_ir", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ov", 32'(out_valid), 32'd0);
    check("async_rst_y", 32'(y), 32'd0);
    check("async_rst_ir", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rel_rst_ir", 32'(in_ready), 32'd1);
    tick();
    check("rel_rst_no_residual", 32'(out_valid), 32'd0);

`ifdef MUX_PIPE_STATS_EN
    // Counter saturation
    force dut.beat_cnt_q = 16'hFFFE;
    #1;
    release dut.beat_cnt_q;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sel       = 2'd0;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    check("sat_out_valid", 32'(out_valid), 32'd0);
    check("sat_beat_cnt", 32'(beat_cnt), 32'hFFFF);
    check("sat_err_cnt", 32'(err_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
